crack_dispatch: RTL

- Parametrised successor to the single-core ARC4 key cracker.
- Splits the key space [KEY_START, KEY_END] into CHUNK-sized ranges and hands them to NUM_CORES external crack cores over an en/rdy handshake.
- Collects results, stops all cores on the first hit, and reports the key.
- Sits between the phase top level and an array of crack cores sharing the ciphertext memory.

---
 rtl/arc4_pkg.sv | 20 ++
 rtl/crack_dispatch_pick.sv | 29 ++
 rtl/crack_dispatch.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/arc4_pkg.sv
// Shared types for the ARC4 key-cracker dispatch slice.
// Holds the default key width and the dispatcher and per-core tracker state encodings.
package arc4_pkg;

  localparam int KEY_WIDTH_DEF = 24;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    DRAIN    = 2'd2,
    DONE     = 2'd3
  } disp_state_t;

  typedef enum logic [1:0] {
    T_IDLE   = 2'd0,
    T_LAUNCH = 2'd1,
    T_RUN    = 2'd2
  } trk_state_t;

endpackage

// File: rtl/crack_dispatch_pick.sv
// Lowest-index-first selector: request vector to one-hot grant, valid flag and binary index.
// Latency: combinational.
// Backpressure: none; the grant follows the request vector within the same cycle.
module crack_dispatch_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic          vld,
  output logic [IW-1:0] idx
);

  // Scanning downwards lets the lowest set request overwrite the others.
  always_comb begin
    gnt = '0;
    vld = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        vld    = 1'b1;
        idx    = IW'(i);
      end
    end
  end

endmodule

// File: rtl/crack_dispatch.sv
// Splits [KEY_START, KEY_END] into CHUNK-sized ranges and dispatches them to NUM_CORES crack cores.
// Latency: first core_en 2 cycles after en is accepted, then at most one launch per cycle.
// Backpressure: a range is launched only to a core that is idle and reports core_rdy; en is ignored while rdy=0.
module crack_dispatch
  import arc4_pkg::*;
#(
  parameter int                   NUM_CORES = 2,
  parameter int                   KEY_WIDTH = KEY_WIDTH_DEF,
  parameter int                   CHUNK     = 4096,
  parameter logic [KEY_WIDTH-1:0] KEY_START = '0,
  parameter logic [KEY_WIDTH-1:0] KEY_END   = '1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  output logic                           rdy,
  output logic [KEY_WIDTH-1:0]           key,
  output logic                           key_valid,
  output logic [NUM_CORES-1:0]           core_en,
  output logic [NUM_CORES*KEY_WIDTH-1:0] core_base,
  output logic [NUM_CORES*KEY_WIDTH-1:0] core_end,
  output logic                           core_abort,
  input  logic [NUM_CORES-1:0]           core_rdy,
  input  logic [NUM_CORES-1:0]           core_found,
  input  logic [NUM_CORES*KEY_WIDTH-1:0] core_key
);

  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  // One extra bit so a range ending at an all-ones KEY_END cannot wrap to zero.
  localparam int AW = KEY_WIDTH + 1;
  localparam logic [AW-1:0] START_X = {1'b0, KEY_START};
  localparam logic [AW-1:0] END_X   = {1'b0, KEY_END};
  localparam logic [AW-1:0] CHUNK_X = AW'(CHUNK);

  disp_state_t state, state_nx;
  trk_state_t  trk    [NUM_CORES];
  trk_state_t  trk_nx [NUM_CORES];

  logic [AW-1:0]                         next_base;
  logic [AW-1:0]                         chunk_last;
  logic [AW-1:0]                         launch_end;
  logic [NUM_CORES-1:0][KEY_WIDTH-1:0]   base_q;
  logic [NUM_CORES-1:0][KEY_WIDTH-1:0]   end_q;
  logic [NUM_CORES-1:0][KEY_WIDTH-1:0]   core_key_a;

  logic [NUM_CORES-1:0] returning;
  logic [NUM_CORES-1:0] free_req;
  logic [NUM_CORES-1:0] found_req;
  logic [NUM_CORES-1:0] free_gnt;
  logic [NUM_CORES-1:0] found_gnt;
  logic                 free_vld;
  logic                 found_vld;
  logic [IW-1:0]        free_idx;
  logic [IW-1:0]        unused_found_idx;

  logic exhausted;
  logic all_idle;
  logic launch;
  logic hit;
  logic [KEY_WIDTH-1:0] key_sel;

  assign core_key_a = core_key;
  assign core_base  = base_q;
  assign core_end   = end_q;
  assign rdy        = (state == IDLE);

  always_comb begin
    returning = '0;
    free_req  = '0;
    core_en   = '0;
    all_idle  = 1'b1;
    for (int n = 0; n < NUM_CORES; n++) begin
      returning[n] = (trk[n] == T_RUN) && core_rdy[n];
      free_req[n]  = (trk[n] == T_IDLE) && core_rdy[n];
      core_en[n]   = (trk[n] == T_LAUNCH);
      if (trk[n] != T_IDLE) all_idle = 1'b0;
    end
  end

  assign found_req = returning & core_found;

  crack_dispatch_pick #(.N(NUM_CORES), .IW(IW)) u_pick_free (
    .req (free_req),
    .gnt (free_gnt),
    .vld (free_vld),
    .idx (free_idx)
  );

  crack_dispatch_pick #(.N(NUM_CORES), .IW(IW)) u_pick_found (
    .req (found_req),
    .gnt (found_gnt),
    .vld (found_vld),
    .idx (unused_found_idx)
  );

  // One-hot mux of the winning core's key.
  always_comb begin
    key_sel = '0;
    for (int n = 0; n < NUM_CORES; n++) begin
      if (found_gnt[n]) key_sel = key_sel | core_key_a[n];
    end
  end

  assign exhausted  = (next_base > END_X);
  assign chunk_last = next_base + CHUNK_X - AW'(1);
  assign launch_end = (chunk_last > END_X) ? END_X : chunk_last;
  // A hit wins over a launch in the same cycle.
  assign hit        = (state == DISPATCH) && found_vld;
  assign launch     = (state == DISPATCH) && !found_vld && free_vld && !exhausted;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (en) state_nx = DISPATCH;
      DISPATCH: begin
        if (found_vld)                  state_nx = DRAIN;
        else if (exhausted && all_idle) state_nx = DONE;
      end
      DRAIN:    if (all_idle) state_nx = DONE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    for (int n = 0; n < NUM_CORES; n++) begin
      trk_nx[n] = trk[n];
      case (trk[n])
        T_IDLE:   if (launch && free_gnt[n]) trk_nx[n] = T_LAUNCH;
        T_LAUNCH: trk_nx[n] = T_RUN;
        T_RUN:    if (core_rdy[n]) trk_nx[n] = T_IDLE;
        default:  trk_nx[n] = T_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      next_base  <= '0;
      key        <= '0;
      key_valid  <= 1'b0;
      core_abort <= 1'b0;
      base_q     <= '0;
      end_q      <= '0;
      for (int n = 0; n < NUM_CORES; n++) trk[n] <= T_IDLE;
    end else begin
      state      <= state_nx;
      core_abort <= hit;
      for (int n = 0; n < NUM_CORES; n++) trk[n] <= trk_nx[n];
      if ((state == IDLE) && en) begin
        key_valid <= 1'b0;
        next_base <= START_X;
      end
      if (launch) begin
        base_q[free_idx] <= next_base[KEY_WIDTH-1:0];
        end_q[free_idx]  <= launch_end[KEY_WIDTH-1:0];
        next_base        <= next_base + CHUNK_X;
      end
      if (hit) begin
        key       <= key_sel;
        key_valid <= 1'b1;
      end
    end
  end

endmodule
